// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Sequencer-side bundle: ROM fetch, PC control and ALU strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int N        = 4,
    parameter int SIZE_CNT = 3
);
    logic                en;
    logic [N-1:0]        pc;
    logic [N-1:0]        rom_addr;
    logic [N+3:0]        rom_data;
    logic                zero_flag;
    logic [SIZE_CNT:0]   cnt;
    logic [N+3:0]        ir;
    logic                pc_control;
    logic [N-1:0]        jump_addr;
    logic [2:0]          alu_op;
    logic                alu_en;
    logic                acc_we;
    logic                halted;
    logic                illegal;

    modport slave (
        input  en, pc, rom_data, zero_flag,
        output rom_addr, cnt, ir, pc_control, jump_addr,
               alu_op, alu_en, acc_we, halted, illegal
    );

    modport master (
        output en, pc, rom_data, zero_flag,
        input  rom_addr, cnt, ir, pc_control, jump_addr,
               alu_op, alu_en, acc_we, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Machine-cycle phase counter, instruction register and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int N        = 4,
    parameter int SIZE_CNT = 3,
    parameter int CNT_CLK  = 1,
    parameter int CNT_MAX  = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    instr_sequencer_if.slave  bus
);
    localparam logic [SIZE_CNT:0] c_cnt_zero = '0;
    localparam logic [SIZE_CNT:0] c_cnt_one  = (SIZE_CNT+1)'(1);
    localparam logic [SIZE_CNT:0] c_cnt_clk  = (SIZE_CNT+1)'(CNT_CLK);
    localparam logic [SIZE_CNT:0] c_cnt_exe  = (SIZE_CNT+1)'(CNT_CLK + 1);
    localparam logic [SIZE_CNT:0] c_cnt_max  = (SIZE_CNT+1)'(CNT_MAX);

    localparam logic [3:0] c_op_ldi  = 4'h1;
    localparam logic [3:0] c_op_add  = 4'h2;
    localparam logic [3:0] c_op_xor  = 4'h6;
    localparam logic [3:0] c_op_und  = 4'h7;
    localparam logic [3:0] c_op_jmp  = 4'h8;
    localparam logic [3:0] c_op_jz   = 4'h9;
    localparam logic [3:0] c_op_jnz  = 4'hA;
    localparam logic [3:0] c_op_undl = 4'hB;
    localparam logic [3:0] c_op_undh = 4'hE;
    localparam logic [3:0] c_op_halt = 4'hF;

    logic [SIZE_CNT:0] cnt_q, cnt_d;
    logic [N+3:0]      ir_q, ir_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic [3:0] w_opcode;
    logic       w_acc_class;
    logic       w_alu_class;
    logic       w_illegal_op;
    logic       w_branch_taken;

    assign w_opcode     = ir_q[N+3:N];
    assign w_acc_class  = (w_opcode >= c_op_ldi) && (w_opcode <= c_op_xor);
    assign w_alu_class  = (w_opcode >= c_op_add) && (w_opcode <= c_op_xor);
    assign w_illegal_op = (w_opcode == c_op_und) ||
                          ((w_opcode >= c_op_undl) && (w_opcode <= c_op_undh));
    assign w_branch_taken = (w_opcode == c_op_jmp) ||
                            ((w_opcode == c_op_jz)  &&  bus.zero_flag) ||
                            ((w_opcode == c_op_jnz) && !bus.zero_flag);

    // Phase 0 is the only point where a new machine cycle may start; once
    // started, the cycle runs to completion regardless of en.
    always_comb begin
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        if (cnt_q == c_cnt_zero) begin
            if (bus.en && !halted_q) begin
                ir_d  = bus.rom_data;
                cnt_d = c_cnt_one;
            end
        end else if (cnt_q == c_cnt_clk) begin
            if (w_opcode == c_op_halt) begin
                halted_d = 1'b1;
                cnt_d    = c_cnt_zero;
            end else begin
                cnt_d = cnt_q + c_cnt_one;
            end
            if (w_illegal_op) begin
                illegal_d = 1'b1;
            end
        end else if (cnt_q == c_cnt_max) begin
            cnt_d = c_cnt_zero;
        end else begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= c_cnt_zero;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.rom_addr   = bus.pc;
    assign bus.cnt        = cnt_q;
    assign bus.ir         = ir_q;
    assign bus.jump_addr  = ir_q[N-1:0];
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
    assign bus.pc_control = !((cnt_q == c_cnt_clk) && w_branch_taken);
    assign bus.alu_op     = w_acc_class ? w_opcode[2:0] : 3'd0;
    assign bus.alu_en     = (cnt_q == c_cnt_exe) && w_alu_class;
    assign bus.acc_we     = (cnt_q == c_cnt_max) && w_acc_class;
endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed bench for instr_sequencer with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
    localparam int N        = 4;
    localparam int SIZE_CNT = 3;
    localparam int CNT_CLK  = 1;
    localparam int CNT_MAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] rom [16];

    instr_sequencer_if #(.N(N), .SIZE_CNT(SIZE_CNT)) bus ();

    instr_sequencer #(
        .N(N), .SIZE_CNT(SIZE_CNT), .CNT_CLK(CNT_CLK), .CNT_MAX(CNT_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one machine cycle = fetch, resolve at the PC phase, finish.
    int         m_phase;
    logic [7:0] m_ir;
    logic [3:0] m_pc;
    logic       m_halted;
    logic       m_illegal;

    assign bus.pc       = m_pc;
    assign bus.rom_data = rom[bus.rom_addr];

    function automatic bit f_taken(input logic [7:0] instr, input logic z);
        case (instr[7:4])
            4'h8:    return 1'b1;
            4'h9:    return z;
            4'hA:    return !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit f_defined(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                          4'h8, 4'h9, 4'hA, 4'hF};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= 0;
            m_ir      <= 8'h00;
            m_pc      <= 4'h0;
            m_halted  <= 1'b0;
            m_illegal <= 1'b0;
        end else if (m_phase == 0) begin
            if (bus.en && !m_halted) begin
                m_ir    <= rom[m_pc];
                m_phase <= 1;
            end
        end else if (m_phase == CNT_CLK) begin
            m_pc <= f_taken(m_ir, bus.zero_flag) ? m_ir[3:0] : 4'(m_pc + 4'h1);
            if (m_ir[7:4] == 4'hF) begin
                m_halted <= 1'b1;
                m_phase  <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
            if (!f_defined(m_ir[7:4])) m_illegal <= 1'b1;
        end else begin
            m_phase <= (m_phase == CNT_MAX) ? 0 : m_phase + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [3:0] op;
            op = m_ir[7:4];
            chk("cyc_cnt",       32'(bus.cnt),       32'(m_phase));
            chk("cyc_ir",        32'(bus.ir),        32'(m_ir));
            chk("cyc_rom_addr",  32'(bus.rom_addr),  32'(m_pc));
            chk("cyc_jump_addr", 32'(bus.jump_addr), 32'(m_ir[3:0]));
            chk("cyc_halted",    32'(bus.halted),    32'(m_halted));
            chk("cyc_illegal",   32'(bus.illegal),   32'(m_illegal));
            chk("cyc_pc_control", 32'(bus.pc_control),
                32'(!(m_phase == CNT_CLK && f_taken(m_ir, bus.zero_flag))));
            chk("cyc_alu_op", 32'(bus.alu_op),
                (op >= 4'h1 && op <= 4'h6) ? 32'(op[2:0]) : 32'd0);
            chk("cyc_alu_en", 32'(bus.alu_en),
                32'(m_phase == CNT_CLK + 1 && op >= 4'h2 && op <= 4'h6));
            chk("cyc_acc_we", 32'(bus.acc_we),
                32'(m_phase == CNT_MAX && op >= 4'h1 && op <= 4'h6));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset is applied between edges so its effect is visible without a clock.
    task automatic do_reset(input logic en_val);
        rst = 1'b1;
        #1;
        chk("rst_cnt",     32'(bus.cnt),        32'd0);
        chk("rst_ir",      32'(bus.ir),         32'd0);
        chk("rst_halted",  32'(bus.halted),     32'd0);
        chk("rst_illegal", 32'(bus.illegal),    32'd0);
        chk("rst_pcctl",   32'(bus.pc_control), 32'd1);
        chk("rst_alu_en",  32'(bus.alu_en),     32'd0);
        chk("rst_acc_we",  32'(bus.acc_we),     32'd0);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        bus.en = en_val;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] jv_instr [4] = '{8'h93, 8'h93, 8'hA3, 8'hA3};
    logic       jv_z     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] jv_pc    [4] = '{4'h3, 4'h1, 4'h1, 4'h3};
    logic [3:0] nop_cnt  [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    initial begin
        bus.en        = 1'b0;
        bus.zero_flag = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        #1;

        // NOP stream: phase sequence and PC progression
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("nop_cnt_seq", 32'(bus.cnt), 32'(nop_cnt[k]));
        end
        chk("nop_pc", 32'(bus.rom_addr), 32'd2);

        // JMP 0xA
        do_reset(1'b1);
        rom[0]  = 8'h8A;
        rom[10] = 8'h15;
        tick();
        chk("jmp_ir",    32'(bus.ir),         32'h8A);
        chk("jmp_pcctl", 32'(bus.pc_control), 32'd0);
        tick();
        chk("jmp_pc", 32'(bus.rom_addr), 32'hA);
        tick(3);
        chk("jmp_fetch", 32'(bus.ir), 32'h15);

        // Conditional branches
        for (int t = 0; t < 4; t++) begin
            do_reset(1'b1);
            rom[0] = jv_instr[t];
            bus.zero_flag = jv_z[t];
            tick(2);
            chk("cond_pc", 32'(bus.rom_addr), 32'(jv_pc[t]));
            tick(2);
        end
        bus.zero_flag = 1'b0;

        // ADD then LDI strobes
        for (int t = 0; t < 2; t++) begin
            logic [7:0] instr;
            instr = (t == 0) ? 8'h25 : 8'h15;
            do_reset(1'b1);
            rom[0] = instr;
            for (int k = 1; k <= 4; k++) begin
                tick();
                chk("strobe_alu_en", 32'(bus.alu_en), 32'(t == 0 && k == 2));
                chk("strobe_acc_we", 32'(bus.acc_we), 32'(k == 3));
            end
            chk("strobe_alu_op", 32'(bus.alu_op), (t == 0) ? 32'd2 : 32'd1);
        end

        // HALT at address 2
        do_reset(1'b1);
        rom[2] = 8'hF0;
        tick(9);
        chk("halt_pre", 32'(bus.halted), 32'd0);
        tick();
        chk("halt_set", 32'(bus.halted),   32'd1);
        chk("halt_cnt", 32'(bus.cnt),      32'd0);
        chk("halt_pc",  32'(bus.rom_addr), 32'd3);
        tick(4);
        chk("halt_stuck_cnt", 32'(bus.cnt),    32'd0);
        chk("halt_stuck",     32'(bus.halted), 32'd1);

        // Undefined opcode
        do_reset(1'b1);
        rom[0] = 8'h70;
        tick();
        chk("ill_pre", 32'(bus.illegal), 32'd0);
        tick();
        chk("ill_set", 32'(bus.illegal),  32'd1);
        chk("ill_pc",  32'(bus.rom_addr), 32'd1);
        tick(3);
        chk("ill_continue", 32'(bus.cnt), 32'd1);

        // en low in phase 0 holds everything
        do_reset(1'b0);
        rom[0] = 8'h25;
        tick(2);
        chk("en0_cnt", 32'(bus.cnt), 32'd0);
        chk("en0_ir",  32'(bus.ir),  32'd0);
        bus.en = 1'b1;
        tick(4);
        bus.en = 1'b0;
        rom[1] = 8'h8A;
        tick(3);
        chk("en0_frozen_cnt", 32'(bus.cnt), 32'd0);
        chk("en0_frozen_ir",  32'(bus.ir),  32'h25);

        // en dropped mid-cycle
        do_reset(1'b1);
        tick(2);
        bus.en = 1'b0;
        tick();
        chk("endrop_completes", 32'(bus.cnt), 32'd3);
        tick(2);
        chk("endrop_holds", 32'(bus.cnt), 32'd0);

        // Asynchronous reset mid-cycle with sticky state set
        do_reset(1'b1);
        rom[0] = 8'h70;
        rom[1] = 8'h25;
        tick(6);
        chk("arst_pre_cnt", 32'(bus.cnt),     32'd2);
        chk("arst_pre_ir",  32'(bus.ir),      32'h25);
        chk("arst_pre_ill", 32'(bus.illegal), 32'd1);
        do_reset(1'b0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Phase sequencer and instruction register for the 8-bit MCU core.
- Generates the machine-cycle phase count consumed by the program counter. Fetches the instruction word addressed by the current pc from program ROM and decodes it.
- Drives the PC's branch select and jump target. Drives ALU/accumulator strobes for the execute and writeback phases.
- Sits directly upstream of the PC: its cnt, pc_control and jump_addr are the PC's Cnt, PC_Control and Count_ALU inputs.

Parameters:
- N, 4, program address width; operand field width.
- SIZE_CNT, 3, phase counter MSB index; cnt is SIZE_CNT+1 bits.
- CNT_CLK, 1, phase in which the PC updates; legal range 1..CNT_MAX-2.
- CNT_MAX, 3, last phase of a machine cycle; phases run 0..CNT_MAX.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run enable; sampled only in phase 0.
- pc  input  N  current program counter, from the PC.
- rom_addr  output  N  program ROM address, combinationally equal to pc.
- rom_data  input  4+N  ROM read data; asynchronous ROM, valid in the same cycle.
- zero_flag  input  1  accumulator-zero flag from the datapath.
- cnt  output  SIZE_CNT+1  phase count, to PC Cnt.
- ir  output  4+N  instruction register.
- pc_control  output  1  0 = load jump_addr, 1 = increment; to PC.
- jump_addr  output  N  jump target = ir[N-1:0].
- alu_op  output  3  ALU operation select.
- alu_en  output  1  ALU execute strobe.
- acc_we  output  1  accumulator write strobe.
- halted  output  1  sticky halt indication.
- illegal  output  1  sticky undefined-opcode indication.

Behaviour:
- Reset (async, any time, including mid-cycle): cnt=0, ir=0 (NOP), halted=0, illegal=0. Combinational outputs follow: pc_control=1, alu_en=0, acc_we=0, alu_op=0.
- Phase 0, en=0 or halted=1: cnt holds 0; ir unchanged; no fetch.
- Phase 0, en=1 and halted=0: at the clock edge, ir <= rom_data and cnt <= 1.
- en is ignored in phases 1..CNT_MAX; a started machine cycle always completes.
- Phases 1..CNT_MAX-1: cnt increments each clock.
- Phase CNT_MAX: cnt wraps to 0.
- Opcode is ir[N+3:N].
  - 0x0 NOP.
  - 0x1 LDI.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR.
  - 0x8 JMP, 0x9 JZ, 0xA JNZ.
  - 0xF HALT.
  - Anything else executes as NOP and sets illegal at the edge ending phase CNT_CLK.
- pc_control is 0 only while cnt==CNT_CLK and one of:
  - opcode=JMP;
  - opcode=JZ and zero_flag=1;
  - opcode=JNZ and zero_flag=0.
- Otherwise pc_control=1. zero_flag is evaluated combinationally during phase CNT_CLK.
- jump_addr = ir[N-1:0] at all times.
- alu_op = opcode[2:0] for opcodes 0x1..0x6; 0 otherwise.
- alu_en = 1 only while cnt==CNT_CLK+1 and opcode is in 0x2..0x6.
- acc_we = 1 only while cnt==CNT_MAX and opcode is in 0x1..0x6.
- HALT:
  - halted is set at the edge ending phase CNT_CLK.
  - cnt is forced to 0 at that same edge.
  - The PC has already incremented past the HALT, so the post-halt pc is HALT address+1.
  - halted clears only on rst.
- Simultaneous illegal and halt is impossible (distinct opcodes).
- The instruction fetched in phase 0 uses the pc produced by the previous cycle's phase-CNT_CLK update. Fetch-to-branch latency is CNT_CLK cycles.

Test Plan:
- Reset then en=1; ROM[0]=0x00, ROM[1]=0x00 -> cnt sequence 0,1,2,3,0,...; pc_control=1 throughout; alu_en and acc_we never assert; pc visits 0,1,2.
- ROM[0]=0x8A (JMP 0xA) -> ir=0x8A after the first edge; pc_control=0 during cnt==1; PC loads 0xA; the next fetch reads ROM[0xA].
- ROM[0]=0x93 (JZ 3): run once with zero_flag=1 and once with zero_flag=0.
  - zero_flag=1 -> next pc=3.
  - zero_flag=0 -> next pc=1.
  - Repeat with 0xA3 (JNZ 3) -> results inverted.
- ROM[0]=0x25 (ADD) -> alu_op=2; alu_en=1 only at cnt==2; acc_we=1 only at cnt==3.
- ROM[0]=0x15 (LDI) -> acc_we=1 at cnt==3; alu_en stays 0.
- ROM[2]=0xF0 (HALT), preceded by NOPs -> halted=1 after cnt==1 of the third cycle; cnt stuck at 0; pc=3.
- ROM[0]=0x70 (undefined) -> illegal=1 after the first cnt==1; execution continues as NOP.
- en=0 in phase 0 -> cnt held at 0 and ir frozen.
- en dropped at cnt==2 -> cycle completes to cnt==0, then holds.
- Assert rst at cnt==2 -> cnt, ir, halted and illegal clear immediately, without waiting for a clock edge.
